// File: rtl/spi_reg_bank.sv
// spi_reg_bank: byte-stream register file that sits behind spi_slave.
// The first byte of a frame is a command (bit7 = write, low ADDR_W bits = start address,
// the bits in between are reserved and must be zero). Every later byte is a data byte.
// The top address (NUM_REGS-1) is a read-only status slot fed by status_in_i.
// Optional build macro SPI_REG_AUTOINC_EN: advance the address after every data byte
// (burst access). When it is undefined the address stays fixed for the whole frame.
module spi_reg_bank #(
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        frame_active_i,
    input  logic                        rx_valid_i,
    input  logic [7:0]                  rx_data_i,
    output logic [7:0]                  tx_data_o,
    input  logic [7:0]                  status_in_i,
    output logic [8*(2**ADDR_W)-1:0]    regs_flat_o,
    output logic                        wr_strobe_o,
    output logic [ADDR_W-1:0]           wr_addr_o,
    output logic                        frame_err_o
);

    localparam int                NUM_REGS  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS-1);

    typedef enum logic [1:0] {S_CMD, S_WR, S_RD, S_IGNORE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [7:0]          tx_q, tx_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                frame_err_q, frame_err_d;
    logic                reg_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [6:0]          cmd_rsvd;

    // RW storage only; the status slot has no flop behind it.
    logic [7:0]          regs_q [NUM_REGS-1];

`ifdef SPI_REG_AUTOINC_EN
    assign addr_nxt = addr_q + ADDR_W'(1);
`else
    assign addr_nxt = addr_q;
`endif

    assign cmd_addr = rx_data_i[ADDR_W-1:0];
    assign cmd_rsvd = rx_data_i[6:0] >> ADDR_W;

    // Read port: status slot returns the live status input, others the stored byte.
    function automatic logic [7:0] rd_val(input logic [ADDR_W-1:0] a);
        logic [7:0] v;
        v = status_in_i;
        for (int i = 0; i < NUM_REGS-1; i++) begin
            if (a == ADDR_W'(i)) v = regs_q[i];
        end
        return v;
    endfunction

    // Command/data decode; frame end always returns to command state and drops the byte.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        reg_we      = 1'b0;
        if (!frame_active_i) begin
            state_d = S_CMD;
        end else if (rx_valid_i) begin
            case (state_q)
                S_CMD: begin
                    if (|cmd_rsvd) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IGNORE;
                        tx_d        = 8'h00;
                    end else if (rx_data_i[7]) begin
                        state_d = S_WR;
                        addr_d  = cmd_addr;
                        tx_d    = 8'h00;
                    end else begin
                        state_d = S_RD;
                        addr_d  = cmd_addr;
                        tx_d    = rd_val(cmd_addr);
                    end
                end
                S_WR: begin
                    if (addr_q != STAT_ADDR) begin
                        reg_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                    end
                    addr_d = addr_nxt;
                end
                S_RD: begin
                    addr_d = addr_nxt;
                    tx_d   = rd_val(addr_nxt);
                end
                default: ;
            endcase
        end
    end

    // Control state, address pointer and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_CMD;
            addr_q      <= '0;
            tx_q        <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Register bank write port, addressed by the current data pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS-1; i++) regs_q[i] <= RESET_VAL;
        end else if (reg_we) begin
            for (int i = 0; i < NUM_REGS-1; i++) begin
                if (addr_q == ADDR_W'(i)) regs_q[i] <= rx_data_i;
            end
        end
    end

    // Flatten the bank; the status slot is exported as zero.
    for (genvar g = 0; g < NUM_REGS-1; g++) begin : g_flat
        assign regs_flat_o[8*g +: 8] = regs_q[g];
    end
    assign regs_flat_o[8*NUM_REGS-1 -: 8] = 8'h00;

    assign tx_data_o   = tx_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank (ADDR_W=4). Each table row is one clock cycle:
// inputs are applied, the edge happens, outputs are compared 1 time unit later.
// Expectations cover both builds, selected by SPI_REG_AUTOINC_EN.
module tb_spi_reg_bank;

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        frame_active_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic [7:0]  status_in_i = 8'h5A;
    logic [7:0]  tx_data_o;
    logic [127:0] regs_flat_o;
    logic        wr_strobe_o;
    logic [3:0]  wr_addr_o;
    logic        frame_err_o;

    spi_reg_bank #(.ADDR_W(4), .RESET_VAL(8'h00)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_active_i(frame_active_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .tx_data_o(tx_data_o),
        .status_in_i(status_in_i), .regs_flat_o(regs_flat_o),
        .wr_strobe_o(wr_strobe_o), .wr_addr_o(wr_addr_o), .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       rst;
        bit       fa;
        bit       rv;
        bit [7:0] d;
        bit [7:0] st;
        bit [7:0] tx;
        bit       stb;
        bit [3:0] wa;
        bit       err;
        int       ridx;
        bit [7:0] rval;
    } vec_t;

    vec_t vecs [64];
    int   nv = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic add(input bit rst, input bit fa, input bit rv, input bit [7:0] d,
                       input bit [7:0] st, input bit [7:0] tx, input bit stb,
                       input bit [3:0] wa, input bit err, input int ridx, input bit [7:0] rval);
        vecs[nv] = '{rst, fa, rv, d, st, tx, stb, wa, err, ridx, rval};
        nv++;
    endtask

    task automatic chk(input string name, input int row, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit fa, input bit rv, input bit [7:0] d);
        rst_i = rst; frame_active_i = fa; rx_valid_i = rv; rx_data_i = d;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //    rst fa rv data  stat  tx                  stb          wa                   err reg                 val
        add(1, 0, 0, 8'h00, 8'h5A, 8'h00,              0,           4'h0,                0, 0,                  8'h00); // 0 reset
        add(0, 0, 0, 8'h00, 8'h5A, 8'h00,              0,           4'h0,                0, 2,                  8'h00);
        // write 0x82, 0x11, 0x22
        add(0, 1, 1, 8'h82, 8'h5A, 8'h00,              0,           4'h0,                0, 2,                  8'h00);
        add(0, 1, 1, 8'h11, 8'h5A, 8'h00,              1,           4'h2,                0, 2,                  8'h11);
        add(0, 1, 1, 8'h22, 8'h5A, 8'h00,              1,           AI ? 4'h3 : 4'h2,    0, AI ? 3 : 2,         8'h22);
        add(0, 1, 0, 8'h00, 8'h5A, 8'h00,              0,           AI ? 4'h3 : 4'h2,    0, 3,                  AI ? 8'h22 : 8'h00);
        add(0, 0, 0, 8'h00, 8'h5A, 8'h00,              0,           AI ? 4'h3 : 4'h2,    0, 2,                  AI ? 8'h11 : 8'h22);
        // read 0x02, 0xFF, 0xFF
        add(0, 1, 1, 8'h02, 8'h5A, AI ? 8'h11 : 8'h22, 0,           AI ? 4'h3 : 4'h2,    0, 3,                  AI ? 8'h22 : 8'h00);
        add(0, 1, 1, 8'hFF, 8'h5A, 8'h22,              0,           AI ? 4'h3 : 4'h2,    0, 2,                  AI ? 8'h11 : 8'h22);
        add(0, 1, 1, 8'hFF, 8'h5A, AI ? 8'h00 : 8'h22, 0,           AI ? 4'h3 : 4'h2,    0, 4,                  8'h00);
        add(0, 0, 0, 8'h00, 8'h5A, AI ? 8'h00 : 8'h22, 0,           AI ? 4'h3 : 4'h2,    0, 0,                  8'h00); // 10
        // wrap write 0x8E, 0xAA, 0xBB, 0xCC
        add(0, 1, 1, 8'h8E, 8'h5A, 8'h00,              0,           AI ? 4'h3 : 4'h2,    0, 14,                 8'h00);
        add(0, 1, 1, 8'hAA, 8'h5A, 8'h00,              1,           4'hE,                0, 14,                 8'hAA);
        add(0, 1, 1, 8'hBB, 8'h5A, 8'h00,              !AI,         4'hE,                0, 14,                 AI ? 8'hAA : 8'hBB);
        add(0, 1, 1, 8'hCC, 8'h5A, 8'h00,              1,           AI ? 4'h0 : 4'hE,    0, AI ? 0 : 14,        8'hCC);
        add(0, 0, 0, 8'h00, 8'h5A, 8'h00,              0,           AI ? 4'h0 : 4'hE,    0, 15,                 8'h00);
        // read status 0x0F, then one data byte with a different status value
        add(0, 1, 1, 8'h0F, 8'h5A, 8'h5A,              0,           AI ? 4'h0 : 4'hE,    0, 0,                  AI ? 8'hCC : 8'h00);
        add(0, 1, 1, 8'hFF, 8'h3C, AI ? 8'hCC : 8'h3C, 0,           AI ? 4'h0 : 4'hE,    0, 14,                 AI ? 8'hAA : 8'hCC);
        add(0, 0, 0, 8'h00, 8'h5A, AI ? 8'hCC : 8'h3C, 0,           AI ? 4'h0 : 4'hE,    0, 15,                 8'h00);
        // invalid command 0x30, 0x44
        add(0, 1, 1, 8'h30, 8'h5A, 8'h00,              0,           AI ? 4'h0 : 4'hE,    1, 4,                  8'h00);
        add(0, 1, 1, 8'h44, 8'h5A, 8'h00,              0,           AI ? 4'h0 : 4'hE,    0, 0,                  AI ? 8'hCC : 8'h00); // 20
        add(0, 0, 0, 8'h00, 8'h5A, 8'h00,              0,           AI ? 4'h0 : 4'hE,    0, 4,                  8'h00);
        // write 0x81, 0x77
        add(0, 1, 1, 8'h81, 8'h5A, 8'h00,              0,           AI ? 4'h0 : 4'hE,    0, 1,                  8'h00);
        add(0, 1, 1, 8'h77, 8'h5A, 8'h00,              1,           4'h1,                0, 1,                  8'h77);
        add(0, 0, 0, 8'h00, 8'h5A, 8'h00,              0,           4'h1,                0, 1,                  8'h77);
        // write 0x85, 0x12, then frame end together with byte 0x34
        add(0, 1, 1, 8'h85, 8'h5A, 8'h00,              0,           4'h1,                0, 5,                  8'h00);
        add(0, 1, 1, 8'h12, 8'h5A, 8'h00,              1,           4'h5,                0, 5,                  8'h12);
        add(0, 0, 1, 8'h34, 8'h5A, 8'h00,              0,           4'h5,                0, AI ? 6 : 5,         AI ? 8'h00 : 8'h12);
        add(0, 1, 1, 8'h05, 8'h5A, 8'h12,              0,           4'h5,                0, 5,                  8'h12);
        add(0, 0, 0, 8'h00, 8'h5A, 8'h12,              0,           4'h5,                0, 5,                  8'h12);
        // write 0x83, 0x01, 0x02, then reset mid-frame
        add(0, 1, 1, 8'h83, 8'h5A, 8'h00,              0,           4'h5,                0, 3,                  AI ? 8'h22 : 8'h00); // 30
        add(0, 1, 1, 8'h01, 8'h5A, 8'h00,              1,           4'h3,                0, 3,                  8'h01);
        add(0, 1, 1, 8'h02, 8'h5A, 8'h00,              1,           AI ? 4'h4 : 4'h3,    0, AI ? 4 : 3,         8'h02);
        add(0, 1, 0, 8'h00, 8'h5A, 8'h00,              0,           AI ? 4'h4 : 4'h3,    0, 4,                  AI ? 8'h02 : 8'h00);
        add(1, 1, 1, 8'hFF, 8'h5A, 8'h00,              0,           4'h0,                0, 3,                  8'h00);
        add(0, 1, 1, 8'h81, 8'h5A, 8'h00,              0,           4'h0,                0, 3,                  8'h00);
        add(0, 1, 1, 8'h9A, 8'h5A, 8'h00,              1,           4'h1,                0, 1,                  8'h9A);
        add(0, 0, 0, 8'h00, 8'h5A, 8'h00,              0,           4'h1,                0, 1,                  8'h9A);

        for (int r = 0; r < nv; r++) begin
            status_in_i = vecs[r].st;
            cyc(vecs[r].rst, vecs[r].fa, vecs[r].rv, vecs[r].d);
            chk("tx_data",   r, 128'(tx_data_o),   128'(vecs[r].tx));
            chk("wr_strobe", r, 128'(wr_strobe_o), 128'(vecs[r].stb));
            chk("wr_addr",   r, 128'(wr_addr_o),   128'(vecs[r].wa));
            chk("frame_err", r, 128'(frame_err_o), 128'(vecs[r].err));
            chk("reg",       r, 128'(regs_flat_o[vecs[r].ridx*8 +: 8]), 128'(vecs[r].rval));
        end

        // Reset in the middle of a read frame clears the whole bank and the next byte is a command.
        status_in_i = 8'h5A;
        cyc(0, 1, 1, 8'h87);
        cyc(0, 1, 1, 8'h55);
        chk("seq_wr7", 100, 128'(regs_flat_o[7*8 +: 8]), 128'(8'h55));
        cyc(0, 0, 0, 8'h00);
        cyc(0, 1, 1, 8'h07);
        chk("seq_rd7", 101, 128'(tx_data_o), 128'(8'h55));
        cyc(1, 1, 1, 8'hFF);
        chk("seq_rst_bank", 102, regs_flat_o, 128'h0);
        chk("seq_rst_tx",   103, 128'(tx_data_o), 128'h0);
        cyc(0, 1, 1, 8'h0F);
        chk("seq_cmd_after_rst", 104, 128'(tx_data_o), 128'(8'h5A));
        cyc(0, 1, 0, 8'h00);
        chk("seq_no_err", 105, 128'(frame_err_o), 128'h0);
        cyc(0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Byte-level register file that sits directly downstream of spi_slave.
- Consumes each received SPI byte and decodes it as a command/address/data stream.
- Supplies the next byte for spi_slave to shift out on MISO.
- Exposes a small bank of 8-bit control registers plus one read-only status register to the rest of the FPGA.

Parameters:
ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W; address NUM_REGS-1 is the read-only status register
RESET_VAL, 8'h00, reset value of every RW register

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
frame_active  input  1  high while the SPI frame is selected (SSEL decoded and synchronised by spi_slave)
rx_valid  input  1  one-cycle strobe: rx_data holds a complete received byte
rx_data  input  8  received byte
tx_data  output  8  byte that spi_slave loads for the next transfer
status_in  input  8  value returned when reading address NUM_REGS-1
regs_flat  output  8*NUM_REGS  all register contents; reg[i] = bits [8i+7:8i]; status slot reads 0
wr_strobe  output  1  one-cycle pulse per committed register write
wr_addr  output  ADDR_W  address of the write flagged by wr_strobe
frame_err  output  1  one-cycle pulse on an invalid command byte

Behaviour:
- Reset: all RW regs = RESET_VAL; tx_data = 0; wr_strobe = 0; wr_addr = 0; frame_err = 0; state = S_CMD; internal addr = 0.
- Frame structure: the first byte of a frame is the command; every following byte is a data byte.
- Command byte layout:
  - bit7 = 1 means write, 0 means read.
  - bits [ADDR_W-1:0] are the start address.
  - bits [6:ADDR_W] must be 0.
- States: S_CMD, S_WR, S_RD, S_IGNORE.
- Frame end: whenever frame_active = 0 the next state is S_CMD, from any state. rx_valid while frame_active = 0 is ignored.
- S_CMD, on rx_valid:
  - If the reserved bits are nonzero: frame_err = 1 for one cycle; go to S_IGNORE; tx_data = 8'h00.
  - Else write: go to S_WR; tx_data = 8'h00.
  - Else read: go to S_RD; tx_data = reg[addr], or status_in sampled this cycle if addr = NUM_REGS-1.
- S_WR, on rx_valid:
  - If addr != NUM_REGS-1: reg[addr] <= rx_data; wr_strobe = 1 and wr_addr = addr on the following cycle.
  - If addr = NUM_REGS-1: no write and no strobe.
  - Address then advances (see Optional Feature); tx_data unchanged.
- S_RD, on rx_valid:
  - Data byte is discarded.
  - Address advances; tx_data = value at the new address (status_in sampled this cycle if it is the status address).
- S_IGNORE: all bytes are discarded until frame end.
- Latency: tx_data, register contents, wr_strobe and frame_err all update on the clock edge after the rx_valid cycle (1 cycle). No combinational path from rx_* to outputs.
- Simultaneous rx_valid with frame_active = 0: the frame end wins and the byte is discarded.
- Address arithmetic is modulo NUM_REGS (wraps NUM_REGS-1 -> 0).
- rst mid-frame: full reset; the bank stays in S_CMD even if frame_active is still high, so the next byte is treated as a command.

Optional Feature:
- Macro: SPI_REG_AUTOINC_EN.
- Defined: the address increments by 1 (with wrap) after every data byte in S_WR and S_RD, enabling burst access.
- Undefined: the address stays fixed for the whole frame.
  - Repeated writes overwrite the same register.
  - Repeated reads return the same address, re-sampled on each byte.

Test Plan:
- Burst write (AUTOINC, ADDR_W=4): frame with 0x82, 0x11, 0x22 -> reg2 = 0x11, reg3 = 0x22; wr_strobe pulses with wr_addr 2 then 3; tx_data stays 0x00.
- Burst read (AUTOINC): after the write above, frame 0x02, 0xFF, 0xFF -> tx_data = 0x11 one cycle after the command, then 0x22, then reg4 = 0x00.
- Wrap and read-only slot (AUTOINC): frame 0x8E, 0xAA, 0xBB, 0xCC with status_in = 0x5A -> reg14 = 0xAA, reg15 not written (no strobe), reg0 = 0xCC. Then frame 0x0F -> tx_data = 0x5A.
- Invalid command: frame 0x30, 0x44 -> frame_err single pulse; no writes, no wr_strobe. Next frame 0x81, 0x77 -> reg1 = 0x77.
- Abort and simultaneity: frame 0x85, 0x12, then frame_active falls in the same cycle as rx_valid with 0x34 -> reg5 = 0x12, 0x34 discarded. The next frame's first byte is decoded as a command.
- Non-AUTOINC build plus reset: frame 0x83, 0x01, 0x02 -> reg3 = 0x02 and reg4 unchanged. Assert rst mid-frame -> all regs = 0x00, tx_data = 0x00, state = S_CMD.
